tx_in_fifo: RTL and testbench
=============================

Name: tx_in_fifo

Overview:
Parametrised input buffer for the UART transmitter. It replaces the single holding register with a DEPTH-entry FIFO of DATA_WIDTH-bit words. The host pushes words with a valid/ready handshake. The Tx serializer consumes the head word on RegOut and pops it with a DoneFlag pulse at end of frame. Synchronous design with rising-edge detection on DoneFlag; sits between the host interface and the Tx frame FSM.

Parameters:
DATA_WIDTH, 8, data bits per frame word (5..9)
DEPTH, 4, number of FIFO entries; power of two, >= 2
IDLE_WORD, 8'h01 (DATA_WIDTH bits), value driven on RegOut after reset or flush

Ports:
Clock  input  1  system clock, all state updates on its rising edge
ResetN  input  1  asynchronous, active-low reset
DataIn  input  DATA_WIDTH  word from host
DataValid  input  1  host offers DataIn this cycle
DataReady  output  1  buffer can accept a word; equals (Count != DEPTH)
DoneFlag  input  1  Tx frame-complete indication; level, may stay high several cycles
Flush  input  1  synchronous clear of buffer contents
RegOut  output  DATA_WIDTH  word presented to Tx serializer (registered)
OutValid  output  1  RegOut holds an unconsumed word (registered)
Count  output  $clog2(DEPTH+1)  number of stored words, including the one on RegOut
Overflow  output  1  sticky: a push was attempted while DataReady=0

Behaviour:
- Reset (ResetN=0, async): pointers=0, Count=0, OutValid=0, RegOut=IDLE_WORD, Overflow=0, DoneFlag edge register=0. Memory contents don't care.
- Push: DataValid && DataReady at a rising clock edge stores DataIn at the write pointer; write pointer wraps modulo DEPTH.
- Pop event (done_rise): DoneFlag=1 while the previous-cycle DoneFlag sample was 0. One pop per rising edge, regardless of high duration.
- A pop is taken only if OutValid=1. A rise while OutValid=0 is discarded, not remembered.
- Pop removes the head word; the read pointer wraps modulo DEPTH.
- RegOut/OutValid are updated every cycle from the post-operation head:
  - non-empty: RegOut=head word, OutValid=1;
  - empty: OutValid=0 and RegOut holds its last value (no change).
- Latency: a push into an empty buffer at edge N gives RegOut=word and OutValid=1 after edge N+1. A pop at edge N presents the next word after edge N+1. During that one cycle OutValid=0 if the successor is not yet registered; Count reflects the pop immediately.
- Count: +1 on push only, -1 on pop only, unchanged on push+pop in the same cycle.
- Full (Count=DEPTH): DataReady=0, even if a pop occurs the same cycle. A push is never accepted in the full cycle.
- DataValid && !DataReady sets Overflow=1; the word is dropped and the FIFO is unchanged.
- Empty + DataValid + done_rise in the same cycle: push accepted, pop ignored.
- Flush=1 (synchronous) has priority over push/pop:
  - next state equals the reset state except the DoneFlag edge register, which keeps sampling DoneFlag;
  - clears Overflow.
- Reset mid-transfer: all state is lost immediately; DataReady=1 as soon as ResetN deasserts.

Test Plan:
1. Reset, then push 8'hA5 at cycle 1 -> cycle 2: RegOut=8'hA5, OutValid=1, Count=1, DataReady=1.
2. Push 8'h11, 8'h22, 8'h33, 8'h44 back-to-back (DEPTH=4) -> Count=4, DataReady=0. A 5th push of 8'h55 sets Overflow=1; after draining, order 11,22,33,44 is seen and 55 never appears.
3. DoneFlag held high 5 cycles with Count=3 -> exactly one pop, Count=2. A second rising edge pops again.
4. Buffer empty, DataValid with 8'h3C and DoneFlag rise in the same cycle -> 8'h3C retained, Count=1, OutValid=1 next cycle.
5. Count=2 with Overflow=1; assert Flush for 1 cycle -> Count=0, OutValid=0, RegOut=8'h01, Overflow=0, DataReady=1.
6. Assert ResetN=0 asynchronously mid-cycle with Count=3 -> outputs take reset values before the next clock edge. Parameter sweep DATA_WIDTH=9, DEPTH=8 with pointer wrap over 20 words -> data integrity preserved.

Source files
------------

// File: rtl/tx_in_fifo.sv
// rtl/tx_in_fifo.sv - DEPTH-entry input FIFO feeding the UART Tx serializer
module tx_in_fifo #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = DATA_WIDTH'(1)
) (
    input  logic                         Clock,
    input  logic                         ResetN,
    input  logic [DATA_WIDTH-1:0]        DataIn,
    input  logic                         DataValid,
    output logic                         DataReady,
    input  logic                         DoneFlag,
    input  logic                         Flush,
    output logic [DATA_WIDTH-1:0]        RegOut,
    output logic                         OutValid,
    output logic [$clog2(DEPTH+1)-1:0]   Count,
    output logic                         Overflow
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [DATA_WIDTH-1:0] r_reg_out;
    logic                  r_out_valid;
    logic                  r_overflow;
    logic                  r_done_q;

    logic w_ready;
    logic w_push;
    logic w_done_rise;
    logic w_pop;

    // Full is judged on the registered count only, so a same-cycle pop never
    // opens a slot for a push.
    assign w_ready     = (r_count != FULL_CNT);
    assign w_push      = DataValid & w_ready;
    assign w_done_rise = DoneFlag & ~r_done_q;
    // Only a word already presented on RegOut can be consumed; a rise with
    // nothing presented is simply dropped.
    assign w_pop       = w_done_rise & r_out_valid;

    assign DataReady = w_ready;
    assign RegOut    = r_reg_out;
    assign OutValid  = r_out_valid;
    assign Count     = r_count;
    assign Overflow  = r_overflow;

    // Storage array; contents are don't-care after reset, so no reset term.
    always_ff @(posedge Clock) begin
        if (w_push && !Flush) begin
            r_mem[r_wr_ptr] <= DataIn;
        end
    end

    // DoneFlag edge register keeps sampling through a flush.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= DoneFlag;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is 2^n.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (Flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Head register: refreshed from the settled head each cycle; the cycle
    // of a pop shows OutValid=0 while the successor is fetched.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_reg_out   <= IDLE_WORD;
            r_out_valid <= 1'b0;
        end else if (Flush) begin
            r_reg_out   <= IDLE_WORD;
            r_out_valid <= 1'b0;
        end else if (w_pop) begin
            r_out_valid <= 1'b0;
        end else if (r_count != '0) begin
            r_reg_out   <= r_mem[r_rd_ptr];
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    // Sticky flag for a push offered while full; cleared only by flush/reset.
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            r_overflow <= 1'b0;
        end else if (Flush) begin
            r_overflow <= 1'b0;
        end else if (DataValid && !w_ready) begin
            r_overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_in_fifo.sv
// tb/tb_tx_in_fifo.sv - self-checking bench for tx_in_fifo
module tb_tx_in_fifo;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DATA_WIDTH=8, DEPTH=4
    logic [7:0] a_d;
    logic       a_v, a_done, a_fl;
    logic       a_rdy, a_ov, a_ovf;
    logic [7:0] a_ro;
    logic [2:0] a_cnt;

    // DUT B: DATA_WIDTH=9, DEPTH=8
    logic [8:0] b_d;
    logic       b_v, b_done, b_fl;
    logic       b_rdy, b_ov, b_ovf;
    logic [8:0] b_ro;
    logic [3:0] b_cnt;

    tx_in_fifo #(.DATA_WIDTH(8), .DEPTH(4), .IDLE_WORD(8'h01)) u_a (
        .Clock(clk), .ResetN(rst_n), .DataIn(a_d), .DataValid(a_v),
        .DataReady(a_rdy), .DoneFlag(a_done), .Flush(a_fl), .RegOut(a_ro),
        .OutValid(a_ov), .Count(a_cnt), .Overflow(a_ovf)
    );

    tx_in_fifo #(.DATA_WIDTH(9), .DEPTH(8), .IDLE_WORD(9'h001)) u_b (
        .Clock(clk), .ResetN(rst_n), .DataIn(b_d), .DataValid(b_v),
        .DataReady(b_rdy), .DoneFlag(b_done), .Flush(b_fl), .RegOut(b_ro),
        .OutValid(b_ov), .Count(b_cnt), .Overflow(b_ovf)
    );

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       done;
        logic       fl;
        logic       e_rdy;
        logic       e_ov;
        logic [7:0] e_ro;
        logic [2:0] e_cnt;
        logic       e_ovf;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;
    logic [8:0] w [20];

    function automatic vec_t mk(logic v, logic [7:0] d, logic done, logic fl,
                                logic rdy, logic ov, logic [7:0] ro,
                                logic [2:0] cnt, logic ovf);
        vec_t r;
        r.v = v; r.d = d; r.done = done; r.fl = fl;
        r.e_rdy = rdy; r.e_ov = ov; r.e_ro = ro; r.e_cnt = cnt; r.e_ovf = ovf;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] a_tuple();
        return {18'd0, a_rdy, a_ov, a_ro, a_cnt, a_ovf};
    endfunction

    initial begin
        a_v = 0; a_d = 0; a_done = 0; a_fl = 0;
        b_v = 0; b_d = 0; b_done = 0; b_fl = 0;

        //            v  d     dn fl   rdy ov ro    cnt ovf
        vecs.push_back(mk(1, 8'hA5, 0, 0, 1, 0, 8'h01, 1, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'hA5, 1, 0));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'hA5, 0, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'hA5, 0, 0));
        vecs.push_back(mk(1, 8'h11, 0, 0, 1, 0, 8'hA5, 1, 0));
        vecs.push_back(mk(1, 8'h22, 0, 0, 1, 1, 8'h11, 2, 0));
        vecs.push_back(mk(1, 8'h33, 0, 0, 1, 1, 8'h11, 3, 0));
        vecs.push_back(mk(1, 8'h44, 0, 0, 0, 1, 8'h11, 4, 0));
        vecs.push_back(mk(1, 8'h55, 0, 0, 0, 1, 8'h11, 4, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 8'h11, 4, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h11, 3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h22, 3, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h22, 2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h33, 2, 1));
        vecs.push_back(mk(1, 8'h66, 0, 0, 1, 1, 8'h33, 3, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h33, 2, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h44, 2, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h44, 2, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h44, 2, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 1, 8'h44, 2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h44, 2, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h44, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h66, 1, 1));
        vecs.push_back(mk(0, 8'h00, 1, 0, 1, 0, 8'h66, 0, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 0, 8'h66, 0, 1));
        vecs.push_back(mk(1, 8'h3C, 1, 0, 1, 0, 8'h66, 1, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h3C, 1, 1));
        vecs.push_back(mk(1, 8'h77, 0, 0, 1, 1, 8'h3C, 2, 1));
        vecs.push_back(mk(0, 8'h00, 0, 1, 1, 0, 8'h01, 0, 0));
        vecs.push_back(mk(1, 8'h99, 0, 1, 1, 0, 8'h01, 0, 0));
        vecs.push_back(mk(1, 8'h12, 0, 0, 1, 0, 8'h01, 1, 0));
        vecs.push_back(mk(1, 8'h34, 0, 0, 1, 1, 8'h12, 2, 0));
        vecs.push_back(mk(1, 8'h56, 1, 0, 1, 0, 8'h12, 2, 0));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h34, 2, 0));
        vecs.push_back(mk(1, 8'h78, 0, 0, 1, 1, 8'h34, 3, 0));
        vecs.push_back(mk(1, 8'h9A, 0, 0, 0, 1, 8'h34, 4, 0));
        vecs.push_back(mk(1, 8'hBC, 1, 0, 1, 0, 8'h34, 3, 1));
        vecs.push_back(mk(0, 8'h00, 0, 0, 1, 1, 8'h56, 3, 1));

        for (int i = 0; i < 20; i++) w[i] = 9'((i * 37 + 300) % 512);

        // Reset state, checked while reset is held
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", a_tuple(), {18'd0, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0});
        chk("reset_b", {18'd0, b_rdy, b_ov, b_ro, b_cnt, b_ovf},
            {18'd0, 1'b1, 1'b0, 9'h001, 4'd0, 1'b0});
        #2 rst_n = 1'b1;

        // Table-driven sequence on DUT A
        for (int i = 0; i < vecs.size(); i++) begin
            a_v = vecs[i].v; a_d = vecs[i].d; a_done = vecs[i].done; a_fl = vecs[i].fl;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d", i), a_tuple(),
                {18'd0, vecs[i].e_rdy, vecs[i].e_ov, vecs[i].e_ro, vecs[i].e_cnt, vecs[i].e_ovf});
        end
        a_v = 0; a_done = 0; a_fl = 0;

        // Asynchronous reset mid-cycle with Count=3
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset", a_tuple(), {18'd0, 1'b1, 1'b0, 8'h01, 3'd0, 1'b0});
        @(posedge clk);
        #2 rst_n = 1'b1;
        #1;
        chk("post_reset_ready", {31'd0, a_rdy}, 32'd1);

        // DUT B: 20 words through an 8-deep FIFO with pointer wrap
        for (int i = 0; i < 5; i++) begin
            b_v = 1'b1; b_d = w[i];
            @(posedge clk);
            #1;
        end
        b_v = 1'b0;
        @(posedge clk);
        #1;
        chk("b_prefill_cnt", {28'd0, b_cnt}, 32'd5);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("b_word%0d", k), {22'd0, b_ov, b_ro}, {22'd0, 1'b1, w[k]});
            b_done = 1'b1;
            if (k + 5 < 20) begin
                b_v = 1'b1; b_d = w[k + 5];
            end
            @(posedge clk);
            #1;
            b_done = 1'b0; b_v = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("b_drained", {26'd0, b_ov, b_ovf, b_cnt}, {26'd0, 1'b0, 1'b0, 4'd0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
